key_irq_controller: RTL and testbench

Keyboard-side interrupt source for the keyboard-input-simulation CPU. It synchronizes and debounces a raw key line and captures an 8-bit key code on each debounced press. Codes are queued in a small FIFO, and an interrupt request is raised toward the CPU. The CPU acknowledges the interrupt, then reads and pops the queued code through a word-wide data port.

---
 rtl/key_irq_controller.sv | 231 +++++++++++++++++++++++
 tb/tb_key_irq_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_irq_controller.sv
// rtl/key_irq_controller.sv - debounced key capture, key-code FIFO and CPU interrupt source
//
// Ports:
//   clk       in   1   single clock, all state on posedge
//   reset     in   1   asynchronous active-high reset
//   key_raw   in   1   raw key level, asynchronous, high = pressed
//   key_code  in   8   code captured on each debounced press
//   irq_ack   in   1   CPU takes the interrupt (one-cycle pulse)
//   pop       in   1   remove FIFO head (one-cycle pulse)
//   irq       out  1   registered interrupt request
//   data_out  out  32  {24'b0, head code}, zero when the FIFO is empty
//   count     out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//   overflow  out  1   sticky, a press was dropped because the FIFO was full
module key_irq_controller #(
   parameter int FIFO_DEPTH      = 4,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          key_raw,
   input  logic [7:0]                    key_code,
   input  logic                          irq_ack,
   input  logic                          pop,
   output logic                          irq,
   output logic [31:0]                   data_out,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      DB_IDLE,
      DB_PRESS_WAIT,
      DB_PRESSED,
      DB_RELEASE_WAIT
   } db_state_t;

   typedef enum logic [1:0] {
      IRQ_IDLE,
      IRQ_PEND,
      IRQ_SERVICE
   } irq_state_t;

   // synchronizer
   logic r_s1;
   logic r_s2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= key_raw;
         r_s2 <= r_s1;
      end
   end

   // debounce FSM
   db_state_t  r_db_state;
   db_state_t  w_db_next;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_next;
   logic       w_press;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_db_state <= DB_IDLE;
         r_cnt      <= 8'd0;
      end else begin
         r_db_state <= w_db_next;
         r_cnt      <= w_cnt_next;
      end
   end

   always_comb begin
      w_db_next  = r_db_state;
      w_cnt_next = r_cnt;
      w_press    = 1'b0;
      case (r_db_state)
         DB_IDLE: begin
            w_cnt_next = 8'd0;
            if (r_s2) begin
               // a single stable sample is already enough: skip the wait state
               if (DEBOUNCE_CYCLES == 1) begin
                  w_db_next = DB_PRESSED;
                  w_press   = 1'b1;
               end else begin
                  w_db_next  = DB_PRESS_WAIT;
                  w_cnt_next = 8'd1;
               end
            end
         end
         DB_PRESS_WAIT: begin
            if (!r_s2) begin
               w_db_next  = DB_IDLE;
               w_cnt_next = 8'd0;
            end else if (r_cnt == DB_LAST) begin
               w_db_next  = DB_PRESSED;
               w_cnt_next = 8'd0;
               w_press    = 1'b1;
            end else begin
               w_cnt_next = r_cnt + 8'd1;
            end
         end
         DB_PRESSED: begin
            w_cnt_next = 8'd0;
            if (!r_s2) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  w_db_next = DB_IDLE;
               end else begin
                  w_db_next  = DB_RELEASE_WAIT;
                  w_cnt_next = 8'd1;
               end
            end
         end
         DB_RELEASE_WAIT: begin
            if (r_s2) begin
               w_db_next  = DB_PRESSED;
               w_cnt_next = 8'd0;
            end else if (r_cnt == DB_LAST) begin
               w_db_next  = DB_IDLE;
               w_cnt_next = 8'd0;
            end else begin
               w_cnt_next = r_cnt + 8'd1;
            end
         end
         default: begin
            w_db_next  = DB_IDLE;
            w_cnt_next = 8'd0;
         end
      endcase
   end

   // key-code FIFO
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;
   logic             w_full;
   logic             w_empty;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_pop_ok  = pop && !w_empty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign w_push_ok = w_press && (!w_full || w_pop_ok);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push_ok && !w_pop_ok) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop_ok && !w_push_ok) begin
            r_count <= r_count - 1'b1;
         end
         if (w_press && !w_push_ok) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // storage needs no reset: data_out is masked by the empty flag
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= key_code;
      end
   end

   assign data_out = w_empty ? 32'd0 : {24'd0, r_mem[r_rd_ptr]};
   assign count    = r_count;
   assign overflow = r_overflow;

   // interrupt FSM
   irq_state_t r_irq_state;
   irq_state_t w_irq_next;
   logic       r_irq;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq_state <= IRQ_IDLE;
         r_irq       <= 1'b0;
      end else begin
         r_irq_state <= w_irq_next;
         r_irq       <= (w_irq_next == IRQ_PEND);
      end
   end

   always_comb begin
      w_irq_next = r_irq_state;
      case (r_irq_state)
         IRQ_IDLE: begin
            if (!w_empty) begin
               w_irq_next = IRQ_PEND;
            end
         end
         IRQ_PEND: begin
            if (irq_ack) begin
               w_irq_next = IRQ_SERVICE;
            end
         end
         IRQ_SERVICE: begin
            // returning to idle re-raises irq next cycle if codes remain
            if (pop) begin
               w_irq_next = IRQ_IDLE;
            end
         end
         default: begin
            w_irq_next = IRQ_IDLE;
         end
      endcase
   end

   assign irq = r_irq;

endmodule

// File: tb/tb_key_irq_controller.sv
// tb/tb_key_irq_controller.sv - self-checking bench for key_irq_controller
module tb_key_irq_controller;

   localparam int DEPTH = 4;
   localparam int DB    = 4;

   logic        clk      = 1'b0;
   logic        reset    = 1'b0;
   logic        key_raw  = 1'b0;
   logic [7:0]  key_code = 8'd0;
   logic        irq_ack  = 1'b0;
   logic        pop      = 1'b0;
   logic        irq;
   logic [31:0] data_out;
   logic [2:0]  count;
   logic        overflow;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   key_irq_controller #(
      .FIFO_DEPTH      (DEPTH),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .key_raw  (key_raw),
      .key_code (key_code),
      .irq_ack  (irq_ack),
      .pop      (pop),
      .irq      (irq),
      .data_out (data_out),
      .count    (count),
      .overflow (overflow)
   );

   // reference model: key state with a streak of opposite-level samples,
   // a queue of codes, and a pending/serviced interrupt view
   logic       m_s1, m_s2;
   logic       m_down;
   int         m_streak;
   logic [7:0] q[$];
   logic       m_ovf;
   logic       m_irq;
   logic       m_svc;

   task automatic model_reset();
      m_s1 = 1'b0; m_s2 = 1'b0; m_down = 1'b0; m_streak = 0;
      q.delete(); m_ovf = 1'b0; m_irq = 1'b0; m_svc = 1'b0;
   endtask

   task automatic model_edge();
      logic ev;
      int   n;
      logic pop_ok;
      ev = 1'b0;
      if (m_s2 != m_down) begin
         m_streak++;
         if (m_streak == DB) begin
            m_down   = m_s2;
            m_streak = 0;
            ev       = m_down;
         end
      end else begin
         m_streak = 0;
      end
      n = q.size();
      if (m_svc) begin
         if (pop) m_svc = 1'b0;
      end else if (m_irq) begin
         if (irq_ack) begin
            m_irq = 1'b0;
            m_svc = 1'b1;
         end
      end else begin
         m_irq = (n != 0);
      end
      pop_ok = pop && (n > 0);
      if (pop_ok) void'(q.pop_front());
      if (ev) begin
         if (n == DEPTH && !pop_ok) m_ovf = 1'b1;
         else q.push_back(key_code);
      end
      m_s2 = m_s1;
      m_s1 = key_raw;
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1; key_raw = 1'b0; key_code = 8'd0; irq_ack = 1'b0; pop = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic press(input logic [7:0] code);
      key_code = code;
      key_raw  = 1'b1;
      repeat (DB + 4) cycle();
      key_raw  = 1'b0;
      repeat (DB + 4) cycle();
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #1;
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %0b want 0", irq); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
      n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", data_out); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", overflow); end
      apply_reset();
   endtask

   task automatic test_press_latency();
      apply_reset();
      key_code = 8'h20;
      key_raw  = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         cycle();
         n_checks++;
         if (irq !== 1'(e == 7)) begin n_fail++; $display("FAIL latency_irq edge %0d got %0b want %0b", e, irq, (e == 7)); end
         if (e == 5) begin
            n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL latency_early_count got %0d want 0", count); end
         end
         if (e == 6) begin
            n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL latency_count got %0d want 1", count); end
            n_checks++; if (data_out !== 32'h20) begin n_fail++; $display("FAIL latency_data got %h want 20", data_out); end
         end
      end
      key_raw = 1'b0;
      repeat (DB + 4) cycle();
   endtask

   task automatic test_glitch();
      apply_reset();
      key_code = 8'h11;
      key_raw  = 1'b1;
      repeat (3) cycle();
      key_raw = 1'b0;
      repeat (10) cycle();
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL glitch_count got %0d want 0", count); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL glitch_irq got %0b want 0", irq); end
      key_code = 8'h33;
      key_raw  = 1'b1;
      repeat (10) cycle();
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL hold_count got %0d want 1", count); end
      key_code = 8'h44;
      key_raw  = 1'b0;
      repeat (2) cycle();
      key_raw = 1'b1;
      repeat (10) cycle();
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL release_glitch_count got %0d want 1", count); end
      n_checks++; if (data_out !== 32'h33) begin n_fail++; $display("FAIL release_glitch_data got %h want 33", data_out); end
      key_raw = 1'b0;
      repeat (DB + 4) cycle();
   endtask

   task automatic test_overflow();
      logic [31:0] exp_d [4];
      exp_d = '{32'd2, 32'd3, 32'd4, 32'd0};
      apply_reset();
      for (int c = 1; c <= 5; c++) press(8'(c));
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d want 4", count); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", overflow); end
      n_checks++; if (data_out !== 32'd1) begin n_fail++; $display("FAIL ovf_head got %h want 1", data_out); end
      for (int i = 0; i < 4; i++) begin
         pop = 1'b1;
         cycle();
         pop = 1'b0;
         n_checks++; if (data_out !== exp_d[i]) begin n_fail++; $display("FAIL drain_data %0d got %h want %h", i, data_out, exp_d[i]); end
         n_checks++; if (count !== 3'(3 - i)) begin n_fail++; $display("FAIL drain_count %0d got %0d want %0d", i, count, 3 - i); end
      end
   endtask

   task automatic test_handshake();
      apply_reset();
      press(8'h51);
      press(8'h52);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL hs_pending got %0b want 1", irq); end
      irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL hs_ack got %0b want 0", irq); end
      pop = 1'b1; cycle(); pop = 1'b0;
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL hs_pop_same got %0b want 0", irq); end
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL hs_pop_count got %0d want 1", count); end
      cycle();
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL hs_reraise got %0b want 1", irq); end
      n_checks++; if (data_out !== 32'h52) begin n_fail++; $display("FAIL hs_head got %h want 52", data_out); end
      irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL hs_ack2 got %0b want 0", irq); end
      pop = 1'b1; cycle(); pop = 1'b0;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL hs_empty got %0d want 0", count); end
      for (int i = 0; i < 5; i++) begin
         cycle();
         n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL hs_quiet %0d got %0b want 0", i, irq); end
      end
   endtask

   task automatic test_full_push_pop();
      apply_reset();
      for (int i = 0; i < 4; i++) press(8'hA0 + 8'(i));
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", count); end
      key_code = 8'hA4;
      key_raw  = 1'b1;
      repeat (DB + 1) cycle();
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_pre_count got %0d want 4", count); end
      pop = 1'b1; cycle(); pop = 1'b0;
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_pp_count got %0d want 4", count); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pp_ovf got %0b want 0", overflow); end
      n_checks++; if (data_out !== 32'hA1) begin n_fail++; $display("FAIL full_pp_head got %h want a1", data_out); end
      key_raw = 1'b0;
      repeat (DB + 4) cycle();
      for (int i = 2; i <= 4; i++) begin
         pop = 1'b1; cycle(); pop = 1'b0;
         n_checks++; if (data_out !== {24'd0, 8'hA0 + 8'(i)}) begin n_fail++; $display("FAIL wrap_data %0d got %h want %h", i, data_out, 8'hA0 + 8'(i)); end
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int c = 1; c <= 5; c++) press(8'h60 + 8'(c));
      pop = 1'b1; cycle(); pop = 1'b0;
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL mid_pre_count got %0d want 3", count); end
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mid_pre_irq got %0b want 1", irq); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL mid_pre_ovf got %0b want 1", overflow); end
      #3 reset = 1'b1;
      #1;
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_irq got %0b want 0", irq); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", count); end
      n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL mid_data got %h want 0", data_out); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf got %0b want 0", overflow); end
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_random();
      int          hold;
      logic [31:0] exp_d;
      apply_reset();
      hold = 0;
      for (int t = 0; t < 1500; t++) begin
         if (hold == 0) begin
            key_raw = !key_raw;
            hold    = $urandom_range(1, 2 * DB + 2);
         end
         hold--;
         key_code = 8'($urandom);
         pop      = (t < 600) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);
         irq_ack  = ($urandom_range(0, 2) == 0);
         cycle();
         exp_d = (q.size() != 0) ? {24'd0, q[0]} : 32'd0;
         n_checks++; if (irq !== m_irq) begin n_fail++; $display("FAIL rand_irq t=%0d got %0b want %0b", t, irq, m_irq); end
         n_checks++; if (count !== 3'(q.size())) begin n_fail++; $display("FAIL rand_count t=%0d got %0d want %0d", t, count, q.size()); end
         n_checks++; if (data_out !== exp_d) begin n_fail++; $display("FAIL rand_data t=%0d got %h want %h", t, data_out, exp_d); end
         n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rand_ovf t=%0d got %0b want %0b", t, overflow, m_ovf); end
      end
      pop = 1'b0;
      irq_ack = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_press_latency();
      test_glitch();
      test_overflow();
      test_handshake();
      test_full_push_pop();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
